// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch front end.
// Holds the address and instruction widths, the fetch state encoding and the
// packed layout of one prefetch buffer entry. No ports; imported by the
// fetch unit, its buffer and its decoder-side interface.
package cpu_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 32;

    // RUN: fetching normally; STALL: buffer full and nothing leaving;
    // HALTED: fetching suppressed by the halt input.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    // One buffered fetch: the instruction word and the address it came from.
    typedef struct packed {
        logic [INSTR_W-1:0] data;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Decoder-side handshake of the instruction fetch unit.
// Signals:
//   instr_valid  fetch -> decoder  buffer head holds an instruction
//   instr_ready  decoder -> fetch  decoder takes the head this cycle
//   instr_data   fetch -> decoder  head instruction word
//   instr_pc     fetch -> decoder  address the head word was fetched from
// Modports: master (fetch unit side), slave (decoder side).
interface instr_fetch_if;
    import cpu_pkg::*;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr_data;
    logic [ADDR_W-1:0]  instr_pc;

    modport master (
        output instr_valid,
        output instr_data,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_data,
        input  instr_pc,
        output instr_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of DEPTH entries, WIDTH bits each.
// Ports:
//   CLK, RST_N   clock (rising edge) and asynchronous active-low reset
//   push_i       write wdata_i at the tail (taken when not full or popping)
//   pop_i        drop the head entry (taken when not empty)
//   flush_i      empty the buffer; wins over push and pop
//   wdata_i      entry to write
//   rdata_o      head entry, straight from storage registers
//   full_o       DEPTH entries held
//   empty_o      no entries held
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = INSTR_W + ADDR_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             pushOk;
    logic             popOk;

    // A push into a full buffer is only legal when the head leaves in the
    // same cycle; when full the tail slot is the head slot, so the write and
    // the read of that slot never collide within one cycle.
    assign popOk   = pop_i && !empty_o;
    assign pushOk  = push_i && (!full_o || popOk);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rdPtr_q];

    // Storage and pointers. Storage is cleared on reset so the head reads as
    // all zeros until the first word arrives; a flush only rewinds pointers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushOk) begin
                mem_q[wrPtr_q] <= wdata_i;
                wrPtr_q        <= wrPtr_q + PTR_W'(1);
            end
            if (popOk) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            if (pushOk && !popOk) begin
                count_q <= count_q + CNT_W'(1);
            end else if (popOk && !pushOk) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks a 16-bit PC through a combinational program
// ROM and queues {word, pc} pairs in a small prefetch buffer for the decoder.
// Ports:
//   CLK, RST_N    clock (rising edge) and asynchronous active-low reset
//   rom_addr      word address to the ROM (the fetch PC register)
//   rom_data      ROM word for rom_addr, same cycle
//   halt          level; stops new fetches, buffered words still drain
//   redirect      one-cycle pulse: flush buffer and jump to redirect_pc
//   redirect_pc   jump target, sampled with redirect
//   fetchIf       decoder handshake (instr_valid/ready/data/pc)
//   stall_cnt     only with INSTR_FETCH_PERF_EN: saturating count of cycles
//                 with nothing to offer while not halted
// Build option: define INSTR_FETCH_PERF_EN to add the stall_cnt port.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
    parameter int                DEPTH    = 2
) (
    input  logic               CLK,
    input  logic               RST_N,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               halt,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    instr_fetch_if.master      fetchIf
`ifdef INSTR_FETCH_PERF_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    fetch_state_e      state_q;
    fetch_state_e      state_d;
    fetch_entry_t      pushEntry;
    fetch_entry_t      headEntry;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              popEn;
    logic              pushEn;

    // The decoder only influences fetching through the "room in the buffer"
    // test; the ROM address itself always comes straight from a register.
    // A redirect cancels any pop in its cycle since the buffer is discarded.
    assign rom_addr            = pc_q;
    assign popEn               = !fifoEmpty && fetchIf.instr_ready && !redirect;
    assign pushEn              = !halt && !redirect && (!fifoFull || popEn);
    assign pushEntry.data      = rom_data;
    assign pushEntry.pc        = pc_q;
    assign fetchIf.instr_valid = !fifoEmpty;
    assign fetchIf.instr_data  = headEntry.data;
    assign fetchIf.instr_pc    = headEntry.pc;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W + ADDR_W)
    ) u_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .push_i  (pushEn),
        .pop_i   (popEn),
        .flush_i (redirect),
        .wdata_i (pushEntry),
        .rdata_o (headEntry),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // Next fetch address: a redirect jumps, a push advances (wrapping at the
    // top of the 16-bit space), otherwise the PC holds.
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (pushEn) begin
            pc_d = pc_q + 16'd1;
        end
    end

    // Fetch state tracking. Redirect and halt override the normal
    // RUN/STALL flow; a redirect under halt lands in HALTED.
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = halt ? HALTED : RUN;
        end else if (halt) begin
            state_d = HALTED;
        end else begin
            unique case (state_q)
                RUN:     if (fifoFull && !popEn) state_d = STALL;
                STALL:   if (popEn) state_d = RUN;
                HALTED:  state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // PC and state registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

`ifdef INSTR_FETCH_PERF_EN
    logic [15:0] stallCnt_q;
    logic [15:0] stallCnt_d;

    // Counts cycles where the decoder is starved without a halt to blame;
    // sticks at all-ones and restarts from zero on every redirect.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (redirect) begin
            stallCnt_d = '0;
        end else if (fifoEmpty && !halt && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_d = stallCnt_q + 16'd1;
        end
    end

    // Performance counter register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign stall_cnt = stallCnt_q;
`else
    // No performance counter in this build.
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a default-configured unit and a second
// unit with RESET_PC = 16'hFFFE, both fed by a model ROM returning
// {16'hA5A5, rom_addr}. Expected deliveries are queued as stimulus is
// planned and matched in order as the decoder side consumes words.
module tb_instr_fetch;
    import cpu_pkg::*;

    logic        CLK   = 1'b0;
    logic        RST_N = 1'b1;
    logic        halt;
    logic        redirect;
    logic [15:0] redirectPc;
    logic [15:0] romAddr;
    logic [31:0] romData;
    logic [15:0] romAddr2;
    logic [31:0] romData2;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] expQ[$];
    logic [15:0] exp2Q[$];
`ifdef INSTR_FETCH_PERF_EN
    logic [15:0] stallCnt;
    logic [15:0] stallCnt2;
    logic [15:0] stallSnap;
`endif

    instr_fetch_if busIf ();
    instr_fetch_if busIf2 ();

    always #5 CLK = ~CLK;

    // Model program ROMs.
    assign romData  = {16'hA5A5, romAddr};
    assign romData2 = {16'hA5A5, romAddr2};

    instr_fetch #(
        .RESET_PC (16'h0000),
        .DEPTH    (2)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .rom_addr    (romAddr),
        .rom_data    (romData),
        .halt        (halt),
        .redirect    (redirect),
        .redirect_pc (redirectPc),
        .fetchIf     (busIf.master)
`ifdef INSTR_FETCH_PERF_EN
        ,
        .stall_cnt   (stallCnt)
`endif
    );

    instr_fetch #(
        .RESET_PC (16'hFFFE),
        .DEPTH    (2)
    ) dutWrap (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .rom_addr    (romAddr2),
        .rom_data    (romData2),
        .halt        (1'b0),
        .redirect    (1'b0),
        .redirect_pc (16'h0000),
        .fetchIf     (busIf2.master)
`ifdef INSTR_FETCH_PERF_EN
        ,
        .stall_cnt   (stallCnt2)
`endif
    );

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Matches any word the decoder side takes this cycle against the queue.
    task automatic consumeCheck(input string tag);
        logic [15:0] pc;
        if (busIf.instr_valid && busIf.instr_ready && !redirect) begin
            if (expQ.size() == 0) begin
                checkOutput({tag, "_unexpected_valid"}, 32'(busIf.instr_valid), 32'd0);
            end else begin
                pc = expQ.pop_front();
                checkOutput({tag, "_pc"}, 32'(busIf.instr_pc), 32'(pc));
                checkOutput({tag, "_data"}, busIf.instr_data, {16'hA5A5, pc});
            end
        end
        if (busIf2.instr_valid && busIf2.instr_ready) begin
            if (exp2Q.size() == 0) begin
                checkOutput({tag, "_wrap_unexpected_valid"}, 32'(busIf2.instr_valid), 32'd0);
            end else begin
                pc = exp2Q.pop_front();
                checkOutput({tag, "_wrap_pc"}, 32'(busIf2.instr_pc), 32'(pc));
                checkOutput({tag, "_wrap_data"}, busIf2.instr_data, {16'hA5A5, pc});
            end
        end
    endtask

    // Drives one cycle of inputs at a falling edge, scores what the decoder
    // takes on the coming rising edge, and returns at the next falling edge.
    task automatic applyStimulus(input logic rdy, input logic hlt, input logic redir,
                                 input logic [15:0] rpc, input string tag);
        busIf.instr_ready = rdy;
        halt              = hlt;
        redirect          = redir;
        redirectPc        = rpc;
        consumeCheck(tag);
        @(negedge CLK);
    endtask

    // Synchronous-looking reset pulse of one cycle, released at a falling edge.
    task automatic pulseReset();
        busIf.instr_ready = 1'b0;
        halt              = 1'b0;
        redirect          = 1'b0;
        RST_N             = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    // Directed sequence.
    initial begin
        halt               = 1'b0;
        redirect           = 1'b0;
        redirectPc         = 16'h0000;
        busIf.instr_ready  = 1'b0;
        busIf2.instr_ready = 1'b0;
        #1 RST_N = 1'b0;
        repeat (2) @(negedge CLK);

        checkOutput("rst_valid", 32'(busIf.instr_valid), 32'd0);
        checkOutput("rst_data", busIf.instr_data, 32'h0);
        checkOutput("rst_pc", 32'(busIf.instr_pc), 32'h0);
        checkOutput("rst_rom_addr", 32'(romAddr), 32'h0000);
        checkOutput("rst_wrap_rom_addr", 32'(romAddr2), 32'h0000FFFE);
`ifdef INSTR_FETCH_PERF_EN
        checkOutput("rst_stall_cnt", 32'(stallCnt), 32'd0);
`endif

        // Streaming from reset; the wrap unit runs alongside.
        for (int i = 0; i < 4; i++) expQ.push_back(16'(i));
        exp2Q.push_back(16'hFFFE);
        exp2Q.push_back(16'hFFFF);
        exp2Q.push_back(16'h0000);
        exp2Q.push_back(16'h0001);
        busIf2.instr_ready = 1'b1;
        RST_N = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, "A");
        checkOutput("A_first_valid", 32'(busIf.instr_valid), 32'd1);
        checkOutput("A_wrap_first_valid", 32'(busIf2.instr_valid), 32'd1);
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, "A");
        busIf2.instr_ready = 1'b0;
        checkOutput("A_drained", 32'(expQ.size()), 32'd0);
        checkOutput("A_wrap_drained", 32'(exp2Q.size()), 32'd0);

        // Decoder stalled from reset: buffer fills, then streams back-to-back.
        pulseReset();
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, "B");
        checkOutput("B_hold_pc_early", 32'(busIf.instr_pc), 32'h0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, "B");
        checkOutput("B_valid", 32'(busIf.instr_valid), 32'd1);
        checkOutput("B_hold_pc", 32'(busIf.instr_pc), 32'h0);
        checkOutput("B_hold_data", busIf.instr_data, 32'hA5A50000);
        checkOutput("B_rom_addr", 32'(romAddr), 32'h0002);
`ifdef INSTR_FETCH_PERF_EN
        checkOutput("B_stall_cnt", 32'(stallCnt), 32'd1);
`endif
        for (int i = 0; i < 3; i++) expQ.push_back(16'(i));
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, "B");
        checkOutput("B_drained", 32'(expQ.size()), 32'd0);

        // Redirect while the buffer is full.
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, "C");
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0040, "C");
        checkOutput("C_flush_valid", 32'(busIf.instr_valid), 32'd0);
        checkOutput("C_rom_addr", 32'(romAddr), 32'h0040);
        expQ.push_back(16'h0040);
        expQ.push_back(16'h0041);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, "C");
        checkOutput("C_first_valid", 32'(busIf.instr_valid), 32'd1);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, "C");
        checkOutput("C_drained", 32'(expQ.size()), 32'd0);

        // Halt with two words buffered: drain, freeze, resume.
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, "D");
        checkOutput("D_full_rom_addr", 32'(romAddr), 32'h0044);
        expQ.push_back(16'h0042);
        expQ.push_back(16'h0043);
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, "D");
        checkOutput("D_empty_valid", 32'(busIf.instr_valid), 32'd0);
`ifdef INSTR_FETCH_PERF_EN
        stallSnap = stallCnt;
`endif
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, "D");
        checkOutput("D_halt_valid", 32'(busIf.instr_valid), 32'd0);
        checkOutput("D_halt_rom_addr", 32'(romAddr), 32'h0044);
`ifdef INSTR_FETCH_PERF_EN
        checkOutput("D_halt_stall_cnt", 32'(stallCnt), 32'(stallSnap));
`endif
        expQ.push_back(16'h0044);
        expQ.push_back(16'h0045);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, "D");
        checkOutput("D_drained", 32'(expQ.size()), 32'd0);

        // Asynchronous reset mid-stream, away from any clock edge.
        #2 RST_N = 1'b0;
        #1;
        checkOutput("E_async_valid", 32'(busIf.instr_valid), 32'd0);
        checkOutput("E_async_rom_addr", 32'(romAddr), 32'h0000);
        checkOutput("E_async_pc", 32'(busIf.instr_pc), 32'h0);
        @(negedge CLK);
        expQ.delete();
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) expQ.push_back(16'(i));
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, "E");
        checkOutput("E_drained", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC loaded on reset.
REQ-002 SHALL have parameter DEPTH, default 2, prefetch buffer entries (power of two, 2..8).
REQ-003 SHALL have port CLK  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port RST_N  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rom_addr  output  16  word address to combinational program ROM.
REQ-006 SHALL have port rom_data  input  32  ROM word for rom_addr, valid same cycle.
REQ-007 SHALL have port halt  input  1  level; suppresses new fetches while high.
REQ-008 SHALL have port redirect  input  1  single-cycle pulse; flush and jump.
REQ-009 SHALL have port redirect_pc  input  16  target PC, sampled when redirect high.
REQ-010 SHALL have port instr_valid  output  1  buffer head holds an instruction.
REQ-011 SHALL have port instr_ready  input  1  decoder accepts head this cycle.
REQ-012 SHALL have port instr_data  output  32  head instruction word.
REQ-013 SHALL have port instr_pc  output  16  address the head word was fetched from.

Function
REQ-014 SHALL keep fetch PC register; rom_addr SHALL equal fetch PC combinationally.
REQ-015 SHALL push {rom_data, PC} and increment PC by 1 in a cycle where halt=0, redirect=0, and buffer not full or a pop occurs that cycle.
REQ-016 SHALL pop head when instr_valid && instr_ready; instr_data/instr_pc SHALL hold stable while instr_valid && !instr_ready.
REQ-017 SHALL allow simultaneous push and pop; count unchanged, order preserved.
REQ-018 SHALL wrap PC 16'hFFFF -> 16'h0000 without flag.
REQ-019 SHALL on redirect: clear buffer (instr_valid=0 next cycle), load PC <= redirect_pc, perform no push, and ignore any pop that cycle; redirect SHALL take priority over halt.
REQ-020 SHALL give latency one cycle: word fetched in cycle N is presented at instr_valid in cycle N+1 (registered buffer output).
REQ-021 SHALL sustain one instruction per cycle when instr_ready held high and halt low.
REQ-022 SHALL, while halt high, freeze PC and pushes but continue pops until empty.
REQ-023 SHALL implement states RUN (fetching), STALL (full, no pop), HALTED (halt=1); transitions: RUN->STALL on full, STALL->RUN on pop, any->HALTED on halt, HALTED->RUN on halt=0; redirect returns to RUN unless halt high.

Reset
REQ-024 SHALL on RST_N low, asynchronously: PC=RESET_PC, buffer empty, instr_valid=0, instr_data=0, instr_pc=0, state RUN, perf counter 0.
REQ-025 SHALL, on reset assertion mid-operation, discard all buffered words; first fetch occurs in first clock edge after RST_N rises.

Configuration
REQ-026 SHALL, with macro INSTR_FETCH_PERF_EN defined, add output stall_cnt (16 bit) counting cycles with instr_valid=0 and halt=0, saturating at 16'hFFFF, cleared by reset and redirect.
REQ-027 SHALL, without INSTR_FETCH_PERF_EN, omit stall_cnt port and its logic entirely.

Structure
REQ-028 SHALL place ADDR_W=16, INSTR_W=32, and fetch state enum (RUN, STALL, HALTED) in shared package cpu_pkg.
REQ-029 SHALL implement buffer as sub-module fetch_fifo (synchronous FIFO, width INSTR_W+ADDR_W, depth DEPTH, push/pop/full/empty, async active-low reset).
REQ-030 SHALL contain no combinational path from instr_ready to rom_addr other than through the full test of REQ-015.

Verification (model ROM: rom_data = {16'hA5A5, rom_addr})
REQ-031 Reset release, instr_ready=1 -> cycle 1 instr_valid=1, instr_pc=16'h0000, instr_data=32'hA5A50000; consecutive PCs 1,2,3 each following cycle.
REQ-032 instr_ready=0 for 5 cycles from reset -> exactly DEPTH=2 words buffered, rom_addr holds 16'h0002, head stable at PC 0; ready=1 then delivers PCs 0,1,2 back-to-back.
REQ-033 redirect=1, redirect_pc=16'h0040 while buffer full -> next cycle instr_valid=0; following cycle instr_pc=16'h0040, data 32'hA5A50040; no stale PCs ever delivered.
REQ-034 RESET_PC=16'hFFFE, ready=1 -> delivered PCs FFFE, FFFF, 0000, 0001.
REQ-035 halt=1 with 2 buffered, ready=1 -> both drain, then instr_valid=0 and rom_addr frozen; halt=0 resumes at frozen PC; with INSTR_FETCH_PERF_EN, stall_cnt unchanged during halt.
REQ-036 RST_N pulsed low mid-stream (not on clock edge) -> instr_valid drops immediately; restart from RESET_PC.
